// File: rtl/kmp_ff_gen_if.sv
// kmp_ff_gen_if: request/response bundle for the KMP failure-table generator.
//   pat_input     : pattern, char k at [k*BYTE +: BYTE]
//   pat_last_idx  : index of the last valid pattern char
//   input_valid   : level-held request
//   busy          : generator working (INIT/COMP)
//   output_valid  : ff_result valid and stable
//   ff_result     : packed table, entry i at [i*MAX_PAT_ADD +: MAX_PAT_ADD]
// master = requester, slave = generator.
interface kmp_ff_gen_if #(
  parameter int BYTE        = 8,
  parameter int MAX_PATTERN = 8,
  parameter int MAX_PAT_ADD = 3
);
  logic [MAX_PATTERN*BYTE-1:0]        pat_input;
  logic [MAX_PAT_ADD-1:0]             pat_last_idx;
  logic                               input_valid;
  logic                               busy;
  logic                               output_valid;
  logic [MAX_PAT_ADD*MAX_PATTERN-1:0] ff_result;

  modport master (
    output pat_input, pat_last_idx, input_valid,
    input  busy, output_valid, ff_result
  );

  modport slave (
    input  pat_input, pat_last_idx, input_valid,
    output busy, output_valid, ff_result
  );
endinterface

// File: rtl/kmp_ff_gen.sv
// kmp_ff_gen: KMP failure-function (prefix table) generator.
// Latches a pattern on request, runs one KMP comparison per cycle and
// presents the packed prefix table on bus.ff_result with output_valid.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : kmp_ff_gen_if.slave (pattern in, handshake, table out)
module kmp_ff_gen #(
  parameter int BYTE        = 8,
  parameter int MAX_PATTERN = 8,
  parameter int MAX_PAT_ADD = 3
) (
  input  logic         clk,
  input  logic         reset,
  kmp_ff_gen_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_COMP, S_DONE} state_e;

  typedef logic [MAX_PAT_ADD-1:0] idx_t;

  state_e                                 state_q, state_d;
  idx_t                                   i_q, i_d;
  idx_t                                   len_q, len_d;
  idx_t                                   last_q, last_d;
  logic [MAX_PATTERN-1:0][BYTE-1:0]       pat_q, pat_d;
  logic [MAX_PATTERN-1:0][MAX_PAT_ADD-1:0] ff_q, ff_d;

  // One KMP step: compare pat[i] with pat[len].
  logic match, wr_en, last_wr;
  assign match   = (pat_q[i_q] == pat_q[len_q]);
  assign wr_en   = match || (len_q == '0);   // step writes entry i
  assign last_wr = wr_en && (i_q == last_q);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; input_valid low in any non-IDLE state returns to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.input_valid) state_d = S_INIT;
      S_INIT: if (!bus.input_valid)                 state_d = S_IDLE;
              else if (bus.pat_last_idx == '0)      state_d = S_DONE;
              else                                  state_d = S_COMP;
      S_COMP: if (!bus.input_valid) state_d = S_IDLE;
              else if (last_wr)     state_d = S_DONE;
      S_DONE: if (!bus.input_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state / registered table
  always_comb begin
    bus.busy         = (state_q == S_INIT) || (state_q == S_COMP);
    bus.output_valid = (state_q == S_DONE);
    bus.ff_result    = ff_q;
  end

  // Datapath next-state
  always_comb begin
    i_d    = i_q;
    len_d  = len_q;
    last_d = last_q;
    pat_d  = pat_q;
    ff_d   = ff_q;
    if (bus.input_valid) begin
      if (state_q == S_INIT) begin
        pat_d  = bus.pat_input;
        last_d = bus.pat_last_idx;
        ff_d   = '0;
        i_d    = idx_t'(1);
        len_d  = '0;
      end else if (state_q == S_COMP) begin
        if (match) begin
          ff_d[i_q] = len_q + idx_t'(1);
          len_d     = len_q + idx_t'(1);
        end else if (len_q != '0) begin
          // fall back along the prefix chain; entry i not yet decided
          len_d = ff_q[len_q - idx_t'(1)];
        end else begin
          ff_d[i_q] = '0;
        end
        // i stops at last so it never walks past the pattern
        if (wr_en && !last_wr) i_d = i_q + idx_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_q    <= '0;
      len_q  <= '0;
      last_q <= '0;
      pat_q  <= '0;
      ff_q   <= '0;
    end else begin
      i_q    <= i_d;
      len_q  <= len_d;
      last_q <= last_d;
      pat_q  <= pat_d;
      ff_q   <= ff_d;
    end
  end

endmodule

// File: tb/tb_kmp_ff_gen.sv
module tb_kmp_ff_gen;
  localparam int BYTE = 8, MP = 8, MPA = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  kmp_ff_gen_if #(.BYTE(BYTE), .MAX_PATTERN(MP), .MAX_PAT_ADD(MPA)) bus ();

  kmp_ff_gen #(.BYTE(BYTE), .MAX_PATTERN(MP), .MAX_PAT_ADD(MPA)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [MPA*MP-1:0] ff;
    int                lat;
    int                bsy;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [MP*BYTE-1:0] mkpat(input string s);
    logic [MP*BYTE-1:0] p = '0;
    for (int k = 0; k < s.len(); k++) p[k*BYTE +: BYTE] = s[k];
    return p;
  endfunction

  function automatic logic [MPA*MP-1:0] pk(input int e[8]);
    logic [MPA*MP-1:0] r = '0;
    for (int k = 0; k < MP; k++) r[k*MPA +: MPA] = e[k][MPA-1:0];
    return r;
  endfunction

  // Drive one request; expected table / latency / busy length pushed on drive,
  // popped and compared when output_valid appears.
  task automatic req(input string s, input logic [MPA-1:0] last,
                     input logic [MPA*MP-1:0] exp_ff, input int n_steps,
                     input int corrupt_cyc, input int hold);
    exp_t e;
    int cyc = 0, bcnt = 0;
    bit got = 0;
    e.ff = exp_ff; e.lat = 2 + n_steps; e.bsy = 1 + n_steps;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.pat_input    = mkpat(s);
    bus.pat_last_idx = last;
    bus.input_valid  = 1'b1;
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == corrupt_cyc) bus.pat_input = '1;
      if (bus.busy) bcnt++;
      if (bus.output_valid) got = 1;
    end
    e = sb.pop_front();
    if (!got) chk({s, "_timeout"}, 32'd0, 32'd1);
    else begin
      chk({s, "_lat"},  cyc,  e.lat);
      chk({s, "_busy"}, bcnt, e.bsy);
      chk({s, "_ff"},   bus.ff_result, e.ff);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({s, "_hold_ov"}, bus.output_valid, 1'b1);
      chk({s, "_hold_ff"}, bus.ff_result, e.ff);
    end
    bus.input_valid = 1'b0;
    @(posedge clk); #1;
    chk({s, "_drop_ov"},   bus.output_valid, 1'b0);
    chk({s, "_drop_busy"}, bus.busy, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    bus.input_valid  = 1'b0;
    bus.pat_input    = '0;
    bus.pat_last_idx = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_ov",   bus.output_valid, 1'b0);
    chk("rst_ff",   bus.ff_result, '0);
    reset = 1'b1;

    req("AAAB", 3'd3, pk('{0,1,2,0,0,0,0,0}), 5, 0, 3);
    req("ABAB", 3'd3, pk('{0,0,1,2,0,0,0,0}), 3, 0, 0);
    req("AAAAAAAA", 3'd7, pk('{0,1,2,3,4,5,6,7}), 7, 0, 0);
    req("ZQ", 3'd0, '0, 0, 0, 1);
    // pattern input trashed after INIT latched it
    req("AAAB", 3'd3, pk('{0,1,2,0,0,0,0,0}), 5, 2, 0);

    // abort mid-COMP
    @(posedge clk); #1;
    bus.pat_input = mkpat("AAAB"); bus.pat_last_idx = 3'd3; bus.input_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_busy_pre", bus.busy, 1'b1);
    bus.input_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", bus.busy, 1'b0);
    begin
      bit seen = 0;
      for (int k = 0; k < 8; k++) begin
        @(posedge clk); #1;
        if (bus.output_valid) seen = 1;
      end
      chk("abort_no_ov", seen, 1'b0);
    end
    req("ABAB", 3'd3, pk('{0,0,1,2,0,0,0,0}), 3, 0, 0);

    // async reset mid-COMP
    @(posedge clk); #1;
    bus.pat_input = mkpat("AAAB"); bus.pat_last_idx = 3'd3; bus.input_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_ff", bus.ff_result, pk('{0,1,0,0,0,0,0,0}));
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_ov",   bus.output_valid, 1'b0);
    chk("mid_rst_ff",   bus.ff_result, '0);
    bus.input_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    req("AABAAB", 3'd5, pk('{0,1,0,1,2,3,0,0}), 6, 0, 0);

    if (sb.size() != 0) chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/kmp_ff_gen.md
# kmp_ff_gen

Failure-function (prefix-table) generator for the KMP string-matching engine. It accepts a pattern and its last index, computes the KMP failure table one comparison per cycle, and presents the packed table on `ff_result` in the same format the KMP processing elements consume. It sits upstream of the PE array as the producer of `ff_result`. It uses the same level-held `input_valid` handshake as the PEs.

## Interface
- `BYTE`, 8: bits per character.
- `MAX_PATTERN`, 8: maximum pattern length in characters. Must equal 2^`MAX_PAT_ADD`.
- `MAX_PAT_ADD`, 3: pattern index width.

Ports (one clock; reset is asynchronous and active-low; the clock and reset ports are named `clk` and `reset`, as in the rest of the codebase):
- `clk` in 1: clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `pat_input` in `MAX_PATTERN*BYTE`: pattern; char k at `[k*BYTE +: BYTE]`.
- `pat_last_idx` in `MAX_PAT_ADD`: index of the last valid pattern char (length − 1).
- `input_valid` in 1: request; level-held for the whole transaction.
- `busy` out 1: high in INIT and COMP.
- `output_valid` out 1: table valid and stable.
- `ff_result` out `MAX_PAT_ADD*MAX_PATTERN`: entry i at `[i*MAX_PAT_ADD +: MAX_PAT_ADD]` is the length of the longest proper prefix of pat[0..i] that is also a suffix of it.

## Operation
- **Reset values** (`reset` low, asynchronous): state IDLE, `busy`=0, `output_valid`=0, `ff_result`=0, internal `i`=0, `len`=0, pattern and last-index latches 0.
- **States:** IDLE, INIT, COMP, DONE.
- **IDLE:**
  - `input_valid`=1 → INIT.
  - Otherwise stay in IDLE; `ff_result` holds its previous table.
- **INIT (one cycle):**
  - Latch `pat_input` and `pat_last_idx` into internal registers. Later input changes are ignored until the next INIT.
  - Clear `ff_result` to 0. Set `i`=1, `len`=0.
  - If the latched last index is 0 → DONE, with `output_valid` set on the same edge. Otherwise → COMP.
- **COMP:** one step per edge, using the latched pattern.
  - `pat[i]==pat[len]`: write `len+1` into entry i, set `len`=`len+1`, and increment i.
  - Mismatch with `len`≠0: set `len` = entry `len−1`. Entry i and `i` are unchanged.
  - Mismatch with `len`=0: write 0 into entry i and increment i.
  - A step that writes entry `last` moves to DONE and sets `output_valid`=1 on the same edge. `i` never exceeds `last`.
- **DONE:**
  - `output_valid`=1 and `ff_result` is stable.
  - When `input_valid` drops → IDLE, with `output_valid`=0 on that edge.
- **Abort:** `input_valid`=0 sampled in INIT or COMP → IDLE on that edge. `output_valid` stays 0; `ff_result` keeps partial contents, which are meaningless while `output_valid`=0.
- **Table padding:** entries above `last` are 0.
- **Entry 0:** always 0.
- **Comparisons:** full `BYTE`-wide equality only.
- **Width:** `len` ≤ `i` ≤ `MAX_PATTERN−1`, so every index fits in `MAX_PAT_ADD` bits and no wrap-around occurs.

## Timing
- **Latency:** let E0 be the edge that samples `input_valid`=1 in IDLE.
  - INIT occupies the cycle after E0.
  - Let N be the number of COMP steps. `output_valid` rises after edge E0+1+N.
  - N=0 when `last`=0.
  - N ≤ 2·`last`−1, bounded by the standard KMP amortization.
- **All outputs are registered.** `busy` is decoded from registered state.
- **Back-to-back requests:** `input_valid` must be low for at least one sampled edge (DONE→IDLE) before a new request is recognised. Holding it high in DONE keeps the table valid indefinitely.
- **Reset:** asserting `reset` mid-operation (any state) clears all outputs immediately. The first request after release follows normal timing.

## Test plan
- "AAAB", `last`=3, `input_valid` held → after 5 COMP steps `output_valid`=1 at E0+6; entries 0..3 = 0,1,2,0; entries 4..7 = 0; `busy` high for 6 cycles.
- "ABAB", `last`=3 → 3 COMP steps, `output_valid` at E0+4, entries = 0,0,1,2. Then "AAAAAAAA", `last`=7 → entries = 0,1,2,3,4,5,6,7, 7 steps.
- `last`=0, any pattern → no COMP, `output_valid` at E0+2, `ff_result`=0. Dropping `input_valid` → `output_valid`=0 next edge, state IDLE.
- Change `pat_input` to all 0xFF one cycle after INIT on the "AAAB" case → result is still 0,1,2,0.
- Drop `input_valid` during COMP of "AAAB" → IDLE next edge, `output_valid` never rises. Re-request "ABAB" → correct table 0,0,1,2.
- Assert `reset` low mid-COMP → `busy`, `output_valid`, `ff_result` all 0 asynchronously. After release, a request for "AABAAB" (`last`=5) → 0,1,0,1,2,3.
